// File: rtl/bm_buf_alloc.sv
// Buffer manager free-list allocator: circular free-pointer FIFO, INIT sweep, alloc/release handling.
// Define BM_BUF_ALLOC_DUP_CHECK_EN to enable the in-use bitmap and duplicate-release detection.
`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 8
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif

module bm_buf_alloc #(
  parameter int NUM_BUFS = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_start,
  input  logic                       rel_buf_valid,
  input  logic [`PORT_ID_NBITS-1:0]  rel_buf_port_id,
  input  logic [`BUF_PTR_NBITS-1:0]  rel_buf_ptr,
  input  logic                       alloc_req,
  output logic                       alloc_ack,
  output logic                       alloc_nack,
  output logic [`BUF_PTR_NBITS-1:0]  alloc_buf_ptr,
  output logic                       init_read_count_valid,
  output logic [`BUF_PTR_NBITS-1:0]  init_read_count_ptr,
  output logic                       init_done,
  output logic [`BUF_PTR_NBITS:0]    free_count,
  output logic                       rel_ovf_err,
  output logic                       dup_rel_err
);

  localparam int PTR_W = `BUF_PTR_NBITS;
  localparam int IDX_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BUFS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFS - 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] head, tail, init_idx;
  logic [PTR_W-1:0] fifo_mem [NUM_BUFS];
  logic [PTR_W-1:0] head_ptr;
  logic             run, init_push, enter_init;
  logic             rel_in_range, rel_full;
  logic             alloc_ok, rel_push, rel_ovf, rel_dup;

  // The releasing port id is carried for debug visibility only.
  logic             unused_port_id;
  assign unused_port_id = ^rel_buf_port_id;

`ifdef BM_BUF_ALLOC_DUP_CHECK_EN
  logic [NUM_BUFS-1:0] in_use;
  logic [IDX_W-1:0]    rel_idx;
  assign rel_idx = rel_buf_ptr[IDX_W-1:0];
`endif

  assign head_ptr = fifo_mem[head];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = INIT;
      INIT:    if (init_idx == LAST_IDX) state_nxt = RUN;
      RUN:     if (init_start) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase

    run          = (state == RUN);
    init_push    = (state == INIT);
    enter_init   = (state != INIT) && (state_nxt == INIT);
    rel_in_range = ({1'b0, rel_buf_ptr} < FULL_CNT);
    rel_full     = (free_count == FULL_CNT);
    alloc_ok     = run && alloc_req && (free_count != '0);
`ifdef BM_BUF_ALLOC_DUP_CHECK_EN
    rel_dup      = run && rel_buf_valid && rel_in_range && !in_use[rel_idx];
`else
    rel_dup      = 1'b0;
`endif
    // A duplicate takes precedence over overflow so only one error is raised.
    rel_ovf      = run && rel_buf_valid && rel_full && !rel_dup;
    rel_push     = run && rel_buf_valid && rel_in_range && !rel_full && !rel_dup;
  end

  assign init_read_count_valid = init_push;
  assign init_read_count_ptr   = init_push ? PTR_W'(init_idx) : '0;
  assign init_done             = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      init_idx      <= '0;
      free_count    <= '0;
      alloc_ack     <= 1'b0;
      alloc_nack    <= 1'b0;
      alloc_buf_ptr <= '0;
      rel_ovf_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      alloc_ack   <= alloc_ok;
      alloc_nack  <= alloc_req && !alloc_ok;
      rel_ovf_err <= rel_ovf;
      if (alloc_ok) alloc_buf_ptr <= head_ptr;

      if (enter_init) begin
        head       <= '0;
        tail       <= '0;
        init_idx   <= '0;
        free_count <= '0;
      end else if (init_push) begin
        tail       <= tail + 1'b1;
        init_idx   <= init_idx + 1'b1;
        free_count <= free_count + 1'b1;
      end else begin
        if (alloc_ok) head <= head + 1'b1;
        if (rel_push) tail <= tail + 1'b1;
        free_count <= free_count + CNT_W'(rel_push) - CNT_W'(alloc_ok);
      end
    end
  end

  // Free-list storage holds data only; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (init_push)     fifo_mem[tail] <= PTR_W'(init_idx);
    else if (rel_push) fifo_mem[tail] <= rel_buf_ptr;
  end

`ifdef BM_BUF_ALLOC_DUP_CHECK_EN
  always_ff @(posedge clk) begin
    if (init_push) begin
      in_use[init_idx] <= 1'b0;
    end else begin
      if (alloc_ok) in_use[head_ptr[IDX_W-1:0]] <= 1'b1;
      if (rel_push) in_use[rel_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_rel_err <= 1'b0;
    else        dup_rel_err <= rel_dup;
  end
`else
  assign dup_rel_err = 1'b0;
`endif

endmodule

// File: tb/tb_bm_buf_alloc.sv
// Directed bench for bm_buf_alloc with NUM_BUFS=8; expectations are hand-derived constants.
`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 8
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif

module tb_bm_buf_alloc;
  localparam int NB = 8;

  logic                      clk;
  logic                      rst_n;
  logic                      init_start;
  logic                      rel_buf_valid;
  logic [`PORT_ID_NBITS-1:0] rel_buf_port_id;
  logic [`BUF_PTR_NBITS-1:0] rel_buf_ptr;
  logic                      alloc_req;
  logic                      alloc_ack;
  logic                      alloc_nack;
  logic [`BUF_PTR_NBITS-1:0] alloc_buf_ptr;
  logic                      init_read_count_valid;
  logic [`BUF_PTR_NBITS-1:0] init_read_count_ptr;
  logic                      init_done;
  logic [`BUF_PTR_NBITS:0]   free_count;
  logic                      rel_ovf_err;
  logic                      dup_rel_err;

  int errors = 0;
  int checks = 0;

  bm_buf_alloc #(.NUM_BUFS(NB)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .init_start            (init_start),
    .rel_buf_valid         (rel_buf_valid),
    .rel_buf_port_id       (rel_buf_port_id),
    .rel_buf_ptr           (rel_buf_ptr),
    .alloc_req             (alloc_req),
    .alloc_ack             (alloc_ack),
    .alloc_nack            (alloc_nack),
    .alloc_buf_ptr         (alloc_buf_ptr),
    .init_read_count_valid (init_read_count_valid),
    .init_read_count_ptr   (init_read_count_ptr),
    .init_done             (init_done),
    .free_count            (free_count),
    .rel_ovf_err           (rel_ovf_err),
    .dup_rel_err           (dup_rel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ini, input logic rv, input int rp, input logic req);
    init_start    = ini;
    rel_buf_valid = rv;
    rel_buf_ptr   = `BUF_PTR_NBITS'(rp);
    alloc_req     = req;
  endtask

  task automatic check_init_sweep(input string tag);
    for (int k = 0; k < NB; k++) begin
      tick();
      chk({tag, "_irc_valid"}, 32'(init_read_count_valid), 1);
      chk({tag, "_irc_ptr"}, 32'(init_read_count_ptr), 32'(k));
    end
    tick();
    chk({tag, "_irc_valid_off"}, 32'(init_read_count_valid), 0);
    chk({tag, "_init_done"}, 32'(init_done), 1);
    chk({tag, "_free_count"}, 32'(free_count), 8);
  endtask

  initial begin
    rst_n = 1'b0;
    rel_buf_port_id = '0;
    drive(0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_free_count", 32'(free_count), 0);
    chk("rst_irc_valid", 32'(init_read_count_valid), 0);
    chk("rst_ack", 32'(alloc_ack), 0);
    chk("rst_nack", 32'(alloc_nack), 0);
    chk("rst_ovf", 32'(rel_ovf_err), 0);
    chk("rst_dup", 32'(dup_rel_err), 0);

    // Reset release: INIT sweep pushes pointers 0..7
    rst_n = 1'b1;
    check_init_sweep("init0");

    // Nine back-to-back requests: 8 acks with ptrs 0..7 then a nack
    drive(0, 0, 0, 1);
    for (int i = 0; i < NB + 1; i++) begin
      tick();
      if (i < NB) begin
        chk("b2b_ack", 32'(alloc_ack), 1);
        chk("b2b_nack", 32'(alloc_nack), 0);
        chk("b2b_ptr", 32'(alloc_buf_ptr), 32'(i));
      end else begin
        chk("b2b_last_ack", 32'(alloc_ack), 0);
        chk("b2b_last_nack", 32'(alloc_nack), 1);
      end
    end
    drive(0, 0, 0, 0);
    tick();
    chk("empty_free_count", 32'(free_count), 0);
    chk("idle_ack", 32'(alloc_ack), 0);
    chk("idle_nack", 32'(alloc_nack), 0);

    // Release into an empty list with a same-cycle request: not granted yet
    drive(0, 1, 3, 1);
    tick();
    chk("relalloc_nack", 32'(alloc_nack), 1);
    chk("relalloc_ack", 32'(alloc_ack), 0);
    chk("relalloc_fc", 32'(free_count), 1);
    drive(0, 0, 0, 1);
    tick();
    chk("regrant_ack", 32'(alloc_ack), 1);
    chk("regrant_ptr", 32'(alloc_buf_ptr), 3);
    chk("regrant_fc", 32'(free_count), 0);

    // Build free_count=3 with pointers 3, 6, 1
    drive(0, 1, 3, 0);
    tick();
    chk("rel_fc1", 32'(free_count), 1);
    drive(0, 1, 6, 0);
    tick();
    drive(0, 1, 1, 0);
    tick();
    chk("rel_fc3", 32'(free_count), 3);

    // Release 5 alongside a request: grant old head 3, count stays 3
    drive(0, 1, 5, 1);
    tick();
    chk("same_cyc_ack", 32'(alloc_ack), 1);
    chk("same_cyc_ptr", 32'(alloc_buf_ptr), 3);
    chk("same_cyc_fc", 32'(free_count), 3);
    drive(0, 0, 0, 0);
    tick();
    chk("same_cyc_fc_hold", 32'(free_count), 3);

    // Fill to 8 by releasing 0, 2, 4, 7, 3
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 2, 0); tick();
    drive(0, 1, 4, 0); tick();
    drive(0, 1, 7, 0); tick();
    drive(0, 1, 3, 0); tick();
    chk("full_fc", 32'(free_count), 8);
    chk("full_no_ovf", 32'(rel_ovf_err), 0);
    chk("full_no_dup", 32'(dup_rel_err), 0);

    // Release into a full list
    drive(0, 1, 2, 0);
    tick();
`ifdef BM_BUF_ALLOC_DUP_CHECK_EN
    chk("ovf_rel_dup", 32'(dup_rel_err), 1);
    chk("ovf_rel_ovf", 32'(rel_ovf_err), 0);
`else
    chk("ovf_rel_ovf", 32'(rel_ovf_err), 1);
    chk("ovf_rel_dup", 32'(dup_rel_err), 0);
`endif
    chk("ovf_fc", 32'(free_count), 8);
    drive(0, 0, 0, 0);
    tick();
    chk("ovf_pulse_end", 32'(rel_ovf_err), 0);
    chk("dup_pulse_end", 32'(dup_rel_err), 0);

    // Allocate one (head holds 6), release it, release it again
    drive(0, 0, 0, 1);
    tick();
    chk("dup_alloc_ack", 32'(alloc_ack), 1);
    chk("dup_alloc_ptr", 32'(alloc_buf_ptr), 6);
    chk("dup_alloc_fc", 32'(free_count), 7);
    drive(0, 1, 6, 0);
    tick();
    chk("dup_rel1_fc", 32'(free_count), 8);
    chk("dup_rel1_dup", 32'(dup_rel_err), 0);
    chk("dup_rel1_ovf", 32'(rel_ovf_err), 0);
    drive(0, 1, 6, 0);
    tick();
`ifdef BM_BUF_ALLOC_DUP_CHECK_EN
    chk("dup_rel2_dup", 32'(dup_rel_err), 1);
    chk("dup_rel2_ovf", 32'(rel_ovf_err), 0);
`else
    chk("dup_rel2_ovf", 32'(rel_ovf_err), 1);
    chk("dup_rel2_dup", 32'(dup_rel_err), 0);
`endif
    chk("dup_rel2_fc", 32'(free_count), 8);

    // Allocate three (1, 5, 0), then re-initialise
    drive(0, 0, 0, 1);
    tick(); chk("pre_init_ptr0", 32'(alloc_buf_ptr), 1);
    tick(); chk("pre_init_ptr1", 32'(alloc_buf_ptr), 5);
    tick(); chk("pre_init_ptr2", 32'(alloc_buf_ptr), 0);
    chk("pre_init_fc", 32'(free_count), 5);
    drive(1, 0, 0, 0);
    tick();
    chk("reinit_done_low", 32'(init_done), 0);
    chk("reinit_fc_clear", 32'(free_count), 0);
    chk("reinit_irc_ptr0", 32'(init_read_count_ptr), 0);
    // Request, release and a second init_start while in INIT
    drive(1, 1, 4, 1);
    tick();
    chk("init_req_nack", 32'(alloc_nack), 1);
    chk("init_req_ack", 32'(alloc_ack), 0);
    chk("init_rel_ovf", 32'(rel_ovf_err), 0);
    chk("init_rel_dup", 32'(dup_rel_err), 0);
    chk("init_irc_ptr1", 32'(init_read_count_ptr), 1);
    drive(0, 0, 0, 0);
    for (int k = 2; k < NB; k++) begin
      tick();
      chk("reinit_irc_ptr", 32'(init_read_count_ptr), 32'(k));
    end
    tick();
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_fc", 32'(free_count), 8);

    // Fresh list grants pointer 0 first
    drive(0, 0, 0, 1);
    tick();
    chk("post_init_ack", 32'(alloc_ack), 1);
    chk("post_init_ptr", 32'(alloc_buf_ptr), 0);

    // Asynchronous reset mid-operation, checked before the next clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(alloc_ack), 0);
    chk("async_rst_ptr", 32'(alloc_buf_ptr), 0);
    chk("async_rst_done", 32'(init_done), 0);
    chk("async_rst_fc", 32'(free_count), 0);
    tick();
    chk("rst_hold_nack", 32'(alloc_nack), 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    check_init_sweep("init1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
